// File: rtl/ppi_port_strobed.sv
// One 8-bit data port of an 8255-style PPI: mode 0 latched output / direct input,
// mode 1 strobed handshake (IBF / OBF_N / INTR). Define OVERRUN_DET_EN to add the 'ovr' flag output.
module ppi_port_strobed #(
    parameter int unsigned      WIDTH   = 8,
    parameter logic [WIDTH-1:0] OUT_RST = '0
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             sel,
    input  logic             RD_N,
    input  logic             WR_N,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] d_out,
    input  logic             mode_wr,
    input  logic             mode1,
    input  logic             dir_in,
    input  logic             inte_wr,
    input  logic             inte_val,
    input  logic [WIDTH-1:0] pa_in,
    output logic [WIDTH-1:0] pa_out,
    output logic             pa_oe,
    input  logic             STB_N,
    input  logic             ACK_N,
    output logic             IBF,
    output logic             OBF_N,
    output logic             INTR
`ifdef OVERRUN_DET_EN
    ,
    output logic             ovr
`endif
);

    logic             mode1_q;
    logic             dir_in_q;
    logic             inte_q;
    logic             pending_q;
    logic             ibf_q;
    logic             obf_n_q;
    logic             intr_q;
    logic [WIDTH-1:0] out_latch;
    logic [WIDTH-1:0] in_latch;
    logic [WIDTH-1:0] rd_src;

    // Previous-cycle copies of the strobe pins; an edge is pin != history.
    logic rd_q, wr_q, stb_q, ack_q;

    logic rd_fall, rd_rise, wr_rise;
    logic stb_fall, stb_rise, ack_fall, ack_rise;
    logic mode1_in, mode1_out;

    assign rd_fall   = sel & rd_q & ~RD_N;
    assign rd_rise   = sel & ~rd_q & RD_N;
    assign wr_rise   = sel & ~wr_q & WR_N;
    assign stb_fall  = stb_q & ~STB_N;
    assign stb_rise  = ~stb_q & STB_N;
    assign ack_fall  = ack_q & ~ACK_N;
    assign ack_rise  = ~ack_q & ACK_N;
    assign mode1_in  = mode1_q & dir_in_q;
    assign mode1_out = mode1_q & ~dir_in_q;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        rd_src = out_latch;
        if (dir_in_q)
            rd_src = mode1_q ? in_latch : pa_in;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rd_q  <= 1'b1;
            wr_q  <= 1'b1;
            stb_q <= 1'b1;
            ack_q <= 1'b1;
        end else begin
            rd_q  <= RD_N;
            wr_q  <= WR_N;
            stb_q <= STB_N;
            ack_q <= ACK_N;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)
            d_out <= '0;
        else if (sel && !RD_N)
            d_out <= rd_src;
        else
            d_out <= '0;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            mode1_q   <= 1'b0;
            dir_in_q  <= 1'b1;
            inte_q    <= 1'b0;
            pending_q <= 1'b0;
            ibf_q     <= 1'b0;
            obf_n_q   <= 1'b1;
            intr_q    <= 1'b0;
            out_latch <= OUT_RST;
            in_latch  <= '0;
        end else if (mode_wr) begin
            // A mode write dominates everything else seen this cycle.
            mode1_q   <= mode1;
            dir_in_q  <= dir_in;
            inte_q    <= 1'b0;
            pending_q <= 1'b0;
            ibf_q     <= 1'b0;
            obf_n_q   <= 1'b1;
            intr_q    <= 1'b0;
            out_latch <= OUT_RST;
        end else begin
            if (wr_rise)
                out_latch <= d_in;
            if (inte_wr)
                inte_q <= inte_val;
            intr_q <= inte_q & pending_q;

            if (mode1_in) begin
                // A new strobe beats a same-cycle read completion (and overruns a full buffer).
                if (stb_fall) begin
                    in_latch <= pa_in;
                    ibf_q    <= 1'b1;
                end else if (rd_rise) begin
                    ibf_q <= 1'b0;
                end
                if (stb_rise)
                    pending_q <= 1'b1;
                else if (rd_fall)
                    pending_q <= 1'b0;
            end

            if (mode1_out) begin
                // Fresh CPU data beats a same-cycle acknowledge.
                if (wr_rise)
                    obf_n_q <= 1'b0;
                else if (ack_fall)
                    obf_n_q <= 1'b1;
                if (wr_rise)
                    pending_q <= 1'b0;
                else if (ack_rise && obf_n_q)
                    pending_q <= 1'b1;
            end
        end
    end

`ifdef OVERRUN_DET_EN
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)
            ovr <= 1'b0;
        else if (mode_wr)
            ovr <= 1'b0;
        else if (mode1_in && stb_fall && ibf_q)
            ovr <= 1'b1;
        else if (rd_rise)
            ovr <= 1'b0;
    end
`endif

    assign pa_out = out_latch;
    assign pa_oe  = ~dir_in_q;
    assign IBF    = ibf_q;
    assign OBF_N  = obf_n_q;
    assign INTR   = intr_q;

endmodule

// File: doc/ppi_port_strobed.md
Name: ppi_port_strobed

Overview:
- Downstream of the PPI control unit: one 8-bit data port (A or B) of the 8255-style PPI.
- Enabled by that port's select bit from the control unit.
- Implements mode 0 (basic latched output / unlatched input) and mode 1 (strobed input or output handshake), including the IBF/OBF_N/INTR handshake flags.
- Runs on the system clock; all bus and handshake pins are sampled and edge-detected internally.

Parameters:
- WIDTH, 8, data width of the port and of the CPU data bus.
- OUT_RST, 0, value loaded into the output latch on reset and on mode write.

Ports:
- CLK  input  1  system clock, all state on rising edge
- RESET_N  input  1  asynchronous active-low reset
- sel  input  1  port select from control unit (control bit for this port)
- RD_N  input  1  CPU read strobe, active low
- WR_N  input  1  CPU write strobe, active low
- d_in  input  WIDTH  CPU write data
- d_out  output  WIDTH  CPU read data, registered
- mode_wr  input  1  one-cycle pulse: load mode1/dir_in, reset port state
- mode1  input  1  mode to load: 0 = mode 0, 1 = mode 1
- dir_in  input  1  direction to load: 1 = input, 0 = output
- inte_wr  input  1  one-cycle pulse: load INTE from inte_val (port C bit set/reset)
- inte_val  input  1  new INTE value
- pa_in  input  WIDTH  external port pins, input side
- pa_out  output  WIDTH  external port pins, output side
- pa_oe  output  1  output enable for the port pins
- STB_N  input  1  mode-1 input strobe from peripheral
- ACK_N  input  1  mode-1 output acknowledge from peripheral
- IBF  output  1  input buffer full
- OBF_N  output  1  output buffer full, active low
- INTR  output  1  interrupt request

Behaviour:
- Reset (async, RESET_N=0): mode 0, dir_in=1, pa_out=OUT_RST, pa_oe=0, d_out=0, IBF=0, OBF_N=1, INTR=0, INTE=0, input latch=0, pending=0. Edge-history regs for RD_N/WR_N/STB_N/ACK_N=1.
- Edge detection: each strobe pin is compared with its previous-cycle register. Its action takes effect at the next CLK edge (1-cycle latency). RD/WR edges count only if sel=1 in the cycle the edge is detected.
- pa_oe = ~dir_in (registered state). pa_out = output latch.
- CPU write (WR_N rising, sel): output latch <= d_in, in any mode. Ignored for input direction except in mode 0 readback.
- CPU read: d_out updates every cycle while sel & ~RD_N, else holds 0. Source:
  - mode 0 input: pa_in registered once.
  - mode 1 input: input latch.
  - output direction: output latch.
- INTR = INTE & pending, registered.
- Mode 0: no handshake. IBF=0, OBF_N=1, pending=0. STB_N/ACK_N ignored.
- Mode 1 input:
  - STB_N falling: input latch <= pa_in, IBF <= 1.
  - STB_N rising: pending <= 1.
  - RD_N falling (sel): pending <= 0.
  - RD_N rising (sel): IBF <= 0.
- Mode 1 output:
  - WR_N rising (sel): latch, OBF_N <= 0, pending <= 0.
  - ACK_N falling: OBF_N <= 1.
  - ACK_N rising with OBF_N=1: pending <= 1.
- Simultaneous events and boundary cases:
  - STB_N falling in the same cycle as RD_N rising: IBF stays 1 and the new data is latched (set wins).
  - WR_N rising in the same cycle as ACK_N falling: OBF_N=0 (new data wins).
  - STB_N falling while IBF=1: latch overwritten (overrun), IBF stays 1.
- mode_wr has priority over every other event that cycle. It loads mode1/dir_in, output latch <= OUT_RST, IBF=0, OBF_N=1, INTE=0, pending=0, INTR=0. Edge-history regs are not reset.
- inte_wr: INTE <= inte_val. Clearing INTE drops INTR next cycle and keeps pending. Setting INTE with pending=1 raises INTR next cycle.
- Reset asserted mid-handshake aborts immediately to the reset values.

Optional Feature:
- OVERRUN_DET_EN defined:
  - Extra output ovr (1 bit, reset 0).
  - Set when STB_N falls in mode 1 input while IBF=1.
  - Cleared by RD_N rising (sel) or mode_wr.
  - Same-cycle set wins.
- Undefined: no ovr port; overrun is silent.

Test Plan:
- Reset, then mode_wr (mode1=0, dir_in=0), write d_in=0xA5 with sel -> pa_out=0xA5 one cycle after WR_N rises, pa_oe=1, OBF_N=1, INTR=0.
- Mode 0 input, pa_in=0x3C, sel & RD_N low -> d_out=0x3C within 2 cycles; d_out=0 after RD_N high.
- Mode 1 input, INTE=1:
  - STB_N pulse with pa_in=0x5A -> IBF=1, then INTR=1 after STB_N rises.
  - RD_N low -> INTR=0, d_out=0x5A.
  - RD_N high -> IBF=0.
- Mode 1 output, INTE=1:
  - write 0x81 -> OBF_N=0, INTR=0.
  - ACK_N low -> OBF_N=1.
  - ACK_N high -> INTR=1.
  - next write -> INTR=0.
- Overlap and control writes:
  - STB_N falling same cycle as RD_N rising -> IBF stays 1, latch = new pa_in.
  - inte_wr 0 with pending -> INTR=0; inte_wr 1 -> INTR=1.
  - mode_wr mid-handshake -> all flags reset, pa_out=OUT_RST.
- Async reset during mode 1 output with OBF_N=0 -> OBF_N=1, pa_oe=0, INTR=0 immediately. With OVERRUN_DET_EN, two STB_N pulses without read -> ovr=1, cleared by read.
